// File: rtl/framebuffer_plot_writer_if.sv
// Pixel-plot and framebuffer write bundle between the drawing FSMs and the plot writer.
// master = drawing side, slave = framebuffer_plot_writer.
interface framebuffer_plot_writer_if;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        plot_ready;
  logic        clr_start;
  logic [2:0]  clr_colour;
  logic        clr_done;
  logic        busy;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;

  modport master (
    output x, y, colour, plot, clr_start, clr_colour,
    input  plot_ready, clr_done, busy, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  x, y, colour, plot, clr_start, clr_colour,
    output plot_ready, clr_done, busy, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/framebuffer_plot_writer.sv
// Plot request FIFO + linear writer for a 160x120x3b framebuffer, with full-screen clear.
// Define FB_DROP_CNT_EN to add drop_cnt, a saturating count of out-of-range requests.
module framebuffer_plot_writer #(
  parameter int XRES       = 160,
  parameter int YRES       = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
`ifdef FB_DROP_CNT_EN
  output logic [7:0] drop_cnt,
`endif
  framebuffer_plot_writer_if.slave bus
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C   = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [7:0]  XLIM      = 8'(XRES);
  localparam logic [6:0]  YLIM      = 7'(YRES);
  localparam logic [14:0] LAST_ADDR = 15'(XRES*YRES-1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;
  state_t state;

  logic [7:0]    fx [FIFO_DEPTH];
  logic [6:0]    fy [FIFO_DEPTH];
  logic [2:0]    fc [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_next;
  logic          rdy_en;
  logic [14:0]   clr_addr;
  logic [2:0]    clr_col;

  logic [14:0]   mem_addr_p1;
  logic [2:0]    mem_data_p1;
  logic          vld_p1;
  logic          clr_done_p1;

  logic          full, empty, accept, in_range, push, pop;
  logic [14:0]   pop_addr;

  // Stage 0: handshake, range check and FIFO bookkeeping
  always_comb begin
    full       = (count == DEPTH_C);
    empty      = (count == '0);
    in_range   = (bus.x < XLIM) && (bus.y < YLIM);
    accept     = bus.plot && bus.plot_ready;
    push       = accept && in_range;
    pop        = !empty && ((state == IDLE) || (state == DRAIN));
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_ONE;
    else if (pop && !push)
      count_next = count - CNT_ONE;
    // y*160 + x as two shifts; fits 15 bits for every in-range entry
    pop_addr = 15'({fy[rd_ptr], 7'b0}) + 15'({fy[rd_ptr], 5'b0}) + 15'(fx[rd_ptr]);
  end

  // rdy_en keeps plot_ready low through reset and for the release edge itself
  assign bus.plot_ready = rdy_en && !full && (state == IDLE);
  assign bus.busy       = !empty || (state != IDLE);
  assign bus.mem_addr   = mem_addr_p1;
  assign bus.mem_data   = mem_data_p1;
  assign bus.mem_we     = vld_p1;
  assign bus.clr_done   = clr_done_p1;

  always_ff @(posedge clk) begin
    if (push) begin
      fx[wr_ptr] <= bus.x;
      fy[wr_ptr] <= bus.y;
      fc[wr_ptr] <= bus.colour;
    end
  end

  // Stage 1: registered framebuffer write port and sequencing FSM
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rdy_en      <= 1'b0;
      clr_addr    <= '0;
      clr_col     <= '0;
      mem_addr_p1 <= '0;
      mem_data_p1 <= '0;
      vld_p1      <= 1'b0;
      clr_done_p1 <= 1'b0;
    end else begin
      rdy_en      <= 1'b1;
      vld_p1      <= 1'b0;
      clr_done_p1 <= 1'b0;
      count       <= count_next;
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        vld_p1      <= 1'b1;
        mem_addr_p1 <= pop_addr;
        mem_data_p1 <= fc[rd_ptr];
      end
      case (state)
        IDLE: begin
          if (bus.clr_start) begin
            clr_col  <= bus.clr_colour;
            clr_addr <= '0;
            // a plot taken in this same cycle must reach memory before the clear
            state    <= (count_next == '0) ? CLEAR : DRAIN;
          end
        end
        DRAIN: begin
          if (count_next == '0)
            state <= CLEAR;
        end
        CLEAR: begin
          vld_p1      <= 1'b1;
          mem_addr_p1 <= clr_addr;
          mem_data_p1 <= clr_col;
          clr_addr    <= clr_addr + 15'd1;
          if (clr_addr == LAST_ADDR)
            state <= DONE;
        end
        DONE: begin
          clr_done_p1 <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FB_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn)
      drop_cnt <= '0;
    else if (accept && !in_range && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_framebuffer_plot_writer.sv
// Scoreboard bench for framebuffer_plot_writer: expected writes are queued at handshake
// time and matched against every mem_we cycle.
`timescale 1ns/1ps
module tb_framebuffer_plot_writer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  framebuffer_plot_writer_if bus();
`ifdef FB_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  framebuffer_plot_writer dut (
    .clk    (clk),
    .resetn (resetn),
`ifdef FB_DROP_CNT_EN
    .drop_cnt (drop_cnt),
`endif
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [17:0] sb[$];
  int n_writes = 0;
  int n_done = 0;
  bit clr_pending = 1'b0;
  bit prev_done = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor and predictor in one process so queue pops and flushes are ordered
  always @(negedge clk) begin
    logic [17:0] e;
    int a;
    if (bus.mem_we === 1'b1) begin
      n_writes++;
      check_val("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("write", {14'd0, bus.mem_addr, bus.mem_data}, {14'd0, e});
      end
    end
    if (bus.clr_done === 1'b1) begin
      n_done++;
      check_val("done_queue_empty", sb.size(), 0);
      check_val("done_one_cycle", prev_done, 0);
      clr_pending = 1'b0;
    end
    prev_done = bus.clr_done;
    if (resetn !== 1'b1) begin
      sb.delete();
      clr_pending = 1'b0;
    end else begin
      if (bus.plot && bus.plot_ready) begin
        if (bus.x < 8'd160 && bus.y < 7'd120) begin
          a = int'(bus.y) * 160 + int'(bus.x);
          sb.push_back({15'(a), bus.colour});
        end
      end
      if (bus.clr_start && !clr_pending) begin
        clr_pending = 1'b1;
        for (int i = 0; i < 19200; i++)
          sb.push_back({15'(i), bus.clr_colour});
      end
    end
  end

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (bus.clr_done === 1'b1) seen = 1'b1;
    end
    check_val("clr_done_seen", seen, 1);
    tick();
    check_val("clr_done_low", bus.clr_done, 0);
  endtask

  task automatic set_pix(input int px, input int py, input int pc);
    bus.x = 8'(px);
    bus.y = 7'(py);
    bus.colour = 3'(pc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, acc;
    bit got, clr_taken, seen;
    int ox[3];
    int oy[3];
    ox = '{160, 0, 159};
    oy = '{0, 120, 119};

    // Reset with plot held high
    bus.plot = 1'b1;
    set_pix(10, 2, 1);
    bus.clr_start = 1'b0;
    bus.clr_colour = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_mem_we", bus.mem_we, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_clr_done", bus.clr_done, 0);
    check_val("rst_ready", bus.plot_ready, 0);
    check_val("rst_addr", bus.mem_addr, 0);
    resetn = 1'b1;
    bus.plot = 1'b0;
    tick();
    check_val("ready_after_rst", bus.plot_ready, 1);

    // Single plot, latency to mem_we
    w0 = n_writes;
    set_pix(5, 3, 5);
    bus.plot = 1'b1;
    @(negedge clk);
    check_val("sp_ready", bus.plot_ready, 1);
    tick();
    bus.plot = 1'b0;
    check_val("sp_we_edge_n", bus.mem_we, 0);
    tick();
    check_val("sp_we", bus.mem_we, 1);
    check_val("sp_addr", bus.mem_addr, 485);
    check_val("sp_data", bus.mem_data, 5);
    repeat (3) tick();
    check_val("sp_count", n_writes - w0, 1);

    // Out-of-range requests are consumed but not written
    w0 = n_writes;
`ifdef FB_DROP_CNT_EN
    d0 = int'(drop_cnt);
`else
    d0 = 0;
`endif
    for (int i = 0; i < 3; i++) begin
      set_pix(ox[i], oy[i], 7);
      bus.plot = 1'b1;
      @(negedge clk);
      check_val("oor_ready", bus.plot_ready, 1);
      tick();
    end
    bus.plot = 1'b0;
    repeat (3) tick();
    check_val("oor_writes", n_writes - w0, 1);
`ifdef FB_DROP_CNT_EN
    check_val("oor_drop_cnt", int'(drop_cnt) - d0, 2);
`endif

    // Three pixels, the last one together with clr_start
    w0 = n_writes;
    d0 = n_done;
    for (int i = 0; i < 3; i++) begin
      set_pix(10 + i, 20 + i, i + 1);
      bus.plot = 1'b1;
      if (i == 2) begin
        bus.clr_start = 1'b1;
        bus.clr_colour = 3'b010;
      end
      @(negedge clk);
      check_val("cp_ready", bus.plot_ready, 1);
      tick();
    end
    bus.plot = 1'b0;
    bus.clr_start = 1'b0;
    wait_done(20000);
    check_val("cp_writes", n_writes - w0, 3 + 19200);
    check_val("cp_done_cnt", n_done - d0, 1);

    // Backpressure: plot held high for 10 cycles, clear forced after 2 accepts
    w0 = n_writes;
    acc = 0;
    clr_taken = 1'b0;
    set_pix(20, 40, 0);
    bus.clr_colour = 3'b011;
    bus.plot = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (clr_taken) check_val("bp_ready_low", bus.plot_ready, 0);
      if (bus.clr_start) clr_taken = 1'b1;
      got = bus.plot && bus.plot_ready;
      if (got) acc++;
      tick();
      bus.clr_start = (acc == 2) && !clr_taken;
      if (got) set_pix(20 + acc, 40 + acc, acc);
    end
    bus.plot = 1'b0;
    bus.clr_start = 1'b0;
    check_val("bp_accepts", acc, 3);
    wait_done(20000);
    check_val("bp_writes", n_writes - w0, 3 + 19200);

    // Reset in the middle of a clear
    d0 = n_done;
    bus.clr_start = 1'b1;
    bus.clr_colour = 3'b110;
    tick();
    bus.clr_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (bus.mem_we === 1'b1 && bus.mem_addr == 15'd1000) seen = 1'b1;
    end
    check_val("mc_reach_1000", seen, 1);
    tick();
    resetn = 1'b0;
    tick();
    check_val("mc_we_off", bus.mem_we, 0);
    check_val("mc_no_done", bus.clr_done, 0);
    check_val("mc_busy", bus.busy, 0);
    resetn = 1'b1;
    tick();
    check_val("mc_ready", bus.plot_ready, 1);
    repeat (3) tick();
    check_val("mc_we_idle", bus.mem_we, 0);
    check_val("mc_busy_idle", bus.busy, 0);
    check_val("mc_done_cnt", n_done - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
